reservation_stations: RTL
=========================

RESERVATION_STATIONS -- requirements
Module: reservation_stations

Interface
REQ-001: The block SHALL use a single clock and a synchronous, active-high reset: one clock; reset is synchronous and active-high.
REQ-002: clk  input  1  rising-edge clock for all state.
REQ-003: reset  input  1  synchronous, active-high; clears all entries.
REQ-004: dispatch_valid  input  1  a decoded instruction is presented for allocation.
REQ-005: dispatch_entry  input  rs_entry  instruction payload: tag, tag_1, tag_2, value_1, value_2, imm, ctrl_bits; busy and id are ignored.
REQ-006: dispatch_ready  output  1  at least one entry is free; combinational from current state.
REQ-007: issue_valid  input  1  the issue stage selected an entry this cycle.
REQ-008: issue_rs_id  input  int  id of the selected entry.
REQ-009: cdb_valid  input  1  common data bus broadcast is valid.
REQ-010: cdb_tag  input  int  producer tag of the broadcast; 0 means "no producer".
REQ-011: cdb_value  input  MemoryWord  broadcast result.
REQ-012: flush  input  1  squash all entries, e.g. on a mispredict.
REQ-013: res_stations  output  rs_entry[`RS_SIZE]  registered entry array feeding the issue stage.
REQ-014: free_count  output  int  number of non-busy entries, 0..`RS_SIZE; combinational from state.

Function
REQ-015: A dispatch SHALL occur when dispatch_valid && dispatch_ready && !flush, writing the lowest-index non-busy entry i with busy=1 and id=i; the write becomes visible on res_stations the next cycle.
REQ-016: When all entries are busy, dispatch_ready SHALL be 0, dispatch_valid SHALL be ignored, and no state SHALL change.
REQ-017: Tag convention: tag_1/tag_2 == 0 means the operand value is valid; a nonzero value names the pending producer.
REQ-018: On cdb_valid with cdb_tag != 0, every busy entry whose tag_1 == cdb_tag SHALL load value_1=cdb_value and clear tag_1 to 0 on the next edge; tag_2/value_2 SHALL behave identically and independently, so both operands can wake in the same cycle.
REQ-019: Dispatch bypass: when the entry being dispatched has tag_1 or tag_2 equal to a valid, nonzero cdb_tag in the same cycle, it SHALL be written with the CDB value and that tag cleared.
REQ-020: A cdb_tag of 0 SHALL never match.
REQ-021: On issue_valid, entry issue_rs_id SHALL have busy cleared on the next edge; other fields MAY retain stale values.
REQ-022: An issue_valid targeting a non-busy entry or an out-of-range id SHALL be ignored.
REQ-023: Simultaneous issue and dispatch: the slot freed by the issue SHALL NOT be reused in the same cycle, because allocation uses pre-edge busy bits.
REQ-024: Simultaneous CDB and issue on the same entry: the issue SHALL take effect and the entry SHALL become free.
REQ-025: flush SHALL clear busy in all entries on the next edge and SHALL override dispatch, issue and CDB updates in that cycle.
REQ-026: free_count SHALL always equal `RS_SIZE minus the number of busy entries.
REQ-027: Latency SHALL be one cycle from dispatch to a visible entry and one cycle from a CDB broadcast to a visible wakeup.

Reset
REQ-028: On reset, every entry SHALL be all-zero (busy=0, all tags 0, all values 0), dispatch_ready=1 and free_count=`RS_SIZE; reset SHALL override flush, dispatch, issue and CDB inputs.
REQ-029: A reset asserted mid-operation SHALL discard all in-flight entries, with no partial state retained.

Structure
REQ-030: rs_entry, control_bits, MemoryWord and `RS_SIZE SHALL come from the shared package/defines and SHALL NOT be redeclared locally.
REQ-031: Free-slot selection SHALL be a sub-module rs_alloc_select: a lowest-index priority encoder over busy bits outputting found and index.

Verification
REQ-032: Reset, then dispatch tag=5, tag_1=0, tag_2=0, value_1=3 -> next cycle entry 0 has busy=1, id=0, value_1=3; free_count=`RS_SIZE-1.
REQ-033: Dispatch with tag_1=7, tag_2=9, then CDB tag=7, value=0x11, then CDB tag=9, value=0x22 -> tag_1=0 with value_1=0x11 one cycle after the first broadcast; tag_2=0 with value_2=0x22 one cycle after the second.
REQ-034: Dispatch tag_1=4 in the same cycle as CDB tag=4, value=0xAB -> entry written with tag_1=0 and value_1=0xAB.
REQ-035: Fill all `RS_SIZE entries -> dispatch_ready=0, free_count=0, and a further dispatch is dropped; then issue id=2 together with a dispatch -> dispatch dropped and entry 2 free; the next dispatch lands in entry 2.
REQ-036: With 3 busy entries, assert flush together with dispatch_valid and CDB -> all entries have busy=0 and free_count=`RS_SIZE the next cycle.
REQ-037: Issue id=6 while entry 6 is not busy, and CDB tag=0 -> no state change.

Source files
------------

// File: rtl/reservation_stations_pkg.sv
// Shared types for the reservation-station slice.
// Provides the station depth, the index width, the machine word type,
// the decoded control bundle and the station entry record.
package reservation_stations_pkg;

  localparam int RS_SIZE  = 8;
  localparam int RS_IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  typedef logic [31:0] MemoryWord;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       branch;
  } control_bits;

  // A tag of 0 means the matching value field already holds the operand.
  typedef struct packed {
    logic        busy;
    int          id;
    int          tag;
    int          tag_1;
    int          tag_2;
    MemoryWord   value_1;
    MemoryWord   value_2;
    MemoryWord   imm;
    control_bits ctrl_bits;
  } rs_entry;

endpackage

// File: rtl/rs_alloc_select.sv
// Lowest-index free-slot picker.
// Ports:
//   busy  - per-entry busy bits
//   found - at least one entry is free
//   index - lowest index whose busy bit is clear (0 when none is free)
module rs_alloc_select
  import reservation_stations_pkg::*;
(
  input  logic [RS_SIZE-1:0]  busy,
  output logic                found,
  output logic [RS_IDX_W-1:0] index
);

  // Scan from the top down so the last hit written is the lowest index.
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        found = 1'b1;
        index = RS_IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/reservation_stations.sv
// Reservation-station array between dispatch and issue.
// Ports:
//   clk, reset      - clock and synchronous active-high reset
//   dispatch_*      - decoded instruction offered for allocation; ready when a slot is free
//   issue_valid/id  - issue stage releases the selected entry
//   cdb_*           - result broadcast used to wake waiting operands
//   flush           - squash every entry
//   res_stations    - registered entry array
//   free_count      - number of non-busy entries
module reservation_stations
  import reservation_stations_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      dispatch_valid,
  input  rs_entry   dispatch_entry,
  output logic      dispatch_ready,
  input  logic      issue_valid,
  input  int        issue_rs_id,
  input  logic      cdb_valid,
  input  int        cdb_tag,
  input  MemoryWord cdb_value,
  input  logic      flush,
  output rs_entry   res_stations [RS_SIZE],
  output int        free_count
);

  logic [RS_SIZE-1:0]  busy_vec;
  logic                alloc_found;
  logic [RS_IDX_W-1:0] alloc_idx;
  logic                cdb_hit;
  rs_entry             rs_next [RS_SIZE];
  rs_entry             new_entry;

  always_comb begin
    free_count = 0;
    for (int i = 0; i < RS_SIZE; i++) begin
      busy_vec[i] = res_stations[i].busy;
      if (!res_stations[i].busy) free_count = free_count + 1;
    end
  end

  rs_alloc_select u_alloc (
    .busy  (busy_vec),
    .found (alloc_found),
    .index (alloc_idx)
  );

  assign dispatch_ready = alloc_found;
  assign cdb_hit        = cdb_valid && (cdb_tag != 0);

  // Allocation looks only at pre-edge busy bits, so the dispatch target is
  // always a free slot and never collides with a wakeup or an issue.
  always_comb begin
    rs_next   = res_stations;
    new_entry = dispatch_entry;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (res_stations[i].busy) begin
        if (cdb_hit && res_stations[i].tag_1 == cdb_tag) begin
          rs_next[i].tag_1   = 0;
          rs_next[i].value_1 = cdb_value;
        end
        if (cdb_hit && res_stations[i].tag_2 == cdb_tag) begin
          rs_next[i].tag_2   = 0;
          rs_next[i].value_2 = cdb_value;
        end
        if (issue_valid && issue_rs_id == i) rs_next[i].busy = 1'b0;
      end
    end
    new_entry.busy = 1'b1;
    new_entry.id   = int'(alloc_idx);
    if (cdb_hit && dispatch_entry.tag_1 == cdb_tag) begin
      new_entry.tag_1   = 0;
      new_entry.value_1 = cdb_value;
    end
    if (cdb_hit && dispatch_entry.tag_2 == cdb_tag) begin
      new_entry.tag_2   = 0;
      new_entry.value_2 = cdb_value;
    end
    if (dispatch_valid && alloc_found) rs_next[alloc_idx] = new_entry;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RS_SIZE; i++) res_stations[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < RS_SIZE; i++) res_stations[i].busy <= 1'b0;
    end else begin
      res_stations <= rs_next;
    end
  end

endmodule
